// File: rtl/pipe_pkg.sv
// Shared constants and control-field layout for pipeline stage registers.
package pipe_pkg;

  // Occupancy encodings reported by a stage (valid entries held).
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // Slot indices inside a stage: main drives the outputs, skid absorbs backpressure.
  localparam int SLOT_MAIN = 0;
  localparam int SLOT_SKID = 1;
  localparam int NUM_SLOTS = 2;

  // Control payload layout shared by stage instances and the hazard unit.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       spare;
  } ctrl_t;

  localparam int CTRL_FIELDS_W = $bits(ctrl_t);

  // Number of valid entries; the skid is only ever valid when main is valid.
  function automatic logic [1:0] occ_count(input logic main_valid, input logic skid_valid);
    logic [1:0] occ;
    if (!main_valid) begin
      occ = OCC_EMPTY;
    end else if (skid_valid) begin
      occ = OCC_FULL;
    end else begin
      occ = OCC_ONE;
    end
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One storage entry (valid, data, ctrl) of a skid-buffered pipeline stage.
// Priority inside the entry: flush > load > clear; with none asserted it holds.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 96,
  parameter int CTRL_W    = CTRL_FIELDS_W,
  parameter bit ZERO_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CTRL_W-1:0] load_ctrl,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [CTRL_W-1:0] ctrl
);

  // Valid and ctrl: any emptying event also zeroes ctrl so a bubble never carries write enables.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (flush || (clear && !load)) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
    end
  end

  // Data: zeroed on flush only when ZERO_DATA is set; a normal drain leaves data in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (flush) begin
      if (ZERO_DATA) begin
        data <= '0;
      end
    end else if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised valid/ready pipeline stage with a two-entry skid buffer.
// in_ready is derived from registered skid state plus hold/flush only, so there is
// no combinational path from out_ready back to in_ready.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 96,
  parameter int CTRL_W    = 9,
  parameter bit ZERO_DATA = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Per-slot storage view (index SLOT_MAIN / SLOT_SKID).
  logic [NUM_SLOTS-1:0] slot_valid;
  logic [DATA_W-1:0]    slot_data      [NUM_SLOTS];
  logic [CTRL_W-1:0]    slot_ctrl      [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_load;
  logic [NUM_SLOTS-1:0] slot_clear;
  logic [DATA_W-1:0]    slot_load_data [NUM_SLOTS];
  logic [CTRL_W-1:0]    slot_load_ctrl [NUM_SLOTS];

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;
  logic normal;

  assign main_valid = slot_valid[SLOT_MAIN];
  assign skid_valid = slot_valid[SLOT_SKID];

  assign in_ready  = !skid_valid && !hold && !flush;
  assign out_valid = main_valid && !hold;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign normal    = !flush && !hold;

  // Slot control: decide which entry loads, which drains, and where main refills from.
  always_comb begin
    slot_load                 = '0;
    slot_clear                = '0;
    slot_load_data[SLOT_MAIN] = in_data;
    slot_load_ctrl[SLOT_MAIN] = in_ctrl;
    slot_load_data[SLOT_SKID] = in_data;
    slot_load_ctrl[SLOT_SKID] = in_ctrl;

    if (normal) begin
      if (!main_valid) begin
        // Empty stage: the incoming payload goes straight to main.
        slot_load[SLOT_MAIN] = in_fire;
      end else if (out_fire) begin
        if (skid_valid) begin
          // Skid refills main; in_ready was low so nothing new arrives this cycle.
          slot_load[SLOT_MAIN]      = 1'b1;
          slot_load_data[SLOT_MAIN] = slot_data[SLOT_SKID];
          slot_load_ctrl[SLOT_MAIN] = slot_ctrl[SLOT_SKID];
          slot_clear[SLOT_SKID]     = 1'b1;
        end else if (in_fire) begin
          // Pass-through: main is replaced in the same cycle it drains.
          slot_load[SLOT_MAIN] = 1'b1;
        end else begin
          slot_clear[SLOT_MAIN] = 1'b1;
        end
      end else begin
        // Main is stalled downstream; park the new payload in the skid.
        slot_load[SLOT_SKID] = in_fire;
      end
    end
  end

  // Two identical storage entries.
  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      pipe_slot #(
        .DATA_W    (DATA_W),
        .CTRL_W    (CTRL_W),
        .ZERO_DATA (ZERO_DATA)
      ) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .load      (slot_load[gi]),
        .clear     (slot_clear[gi]),
        .load_data (slot_load_data[gi]),
        .load_ctrl (slot_load_ctrl[gi]),
        .valid     (slot_valid[gi]),
        .data      (slot_data[gi]),
        .ctrl      (slot_ctrl[gi])
      );
    end
  endgenerate

  assign out_data  = slot_data[SLOT_MAIN];
  assign out_ctrl  = main_valid ? slot_ctrl[SLOT_MAIN] : '0;
  assign occupancy = occ_count(main_valid, skid_valid);

  // Flush statistics: count only flushes that actually discarded something, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (flush && (occupancy != OCC_EMPTY) && (flush_cnt != {CNT_W{1'b1}})) begin
      flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid (flush counter narrowed to 2 bits).
module tb_pipe_stage_skid;

  localparam int DATA_W = 96;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              hold;
  logic              flush;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  flush_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_stage_skid #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .ZERO_DATA (1'b1),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .hold      (hold),
    .flush     (flush),
    .occupancy (occupancy),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    out_ready = 1'b0; hold = 1'b0; flush = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++; if (out_ctrl !== '0) begin failures++; $display("FAIL reset_out_ctrl got=%0h exp=0", out_ctrl); end
    checks++; if (flush_cnt !== 2'd0) begin failures++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    $display("reset: released, occupancy=%0d in_ready=%0b", occupancy, in_ready);
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = DATA_W'(k); in_ctrl = CTRL_W'(k);
      tick();
      $display("stream: sent %0d, out_valid=%0b out_data=%0h occ=%0d", k, out_valid, out_data, occupancy);
      checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(k) || out_ctrl !== CTRL_W'(k))
        begin failures++; $display("FAIL stream_out k=%0d got=%0b/%0h/%0h exp=1/%0h/%0h", k, out_valid, out_data, out_ctrl, k, k); end
      checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occ k=%0d got=%0d exp=1", k, occupancy); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL stream_drain got=%0d/%0b exp=0/0", occupancy, out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'hA; in_ctrl = 9'h011;
    tick();
    in_data = 96'hB; in_ctrl = 9'h022;
    tick();
    in_valid = 1'b0;
    #1;
    $display("backpressure: occ=%0d in_ready=%0b out_data=%0h", occupancy, in_ready, out_data);
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_occ_full got=%0d exp=2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_low got=%0b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b1 || out_data !== 96'hA || out_ctrl !== 9'h011)
      begin failures++; $display("FAIL bp_first got=%0b/%0h/%0h exp=1/a/11", out_valid, out_data, out_ctrl); end
    out_ready = 1'b1;
    tick();
    $display("backpressure: released, out_data=%0h occ=%0d", out_data, occupancy);
    checks++; if (out_valid !== 1'b1 || out_data !== 96'hB || out_ctrl !== 9'h022)
      begin failures++; $display("FAIL bp_second got=%0b/%0h/%0h exp=1/b/22", out_valid, out_data, out_ctrl); end
    checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1)
      begin failures++; $display("FAIL bp_after_a got=%0d/%0b exp=1/1", occupancy, in_ready); end
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0)
      begin failures++; $display("FAIL bp_empty got=%0d/%0b/%0h exp=0/0/0", occupancy, out_valid, out_ctrl); end
  endtask

  task automatic test_hold();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'h55; in_ctrl = 9'h0A3;
    tick();
    hold = 1'b1; out_ready = 1'b1; in_data = 96'h66; in_ctrl = 9'h0C4;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0)
      begin failures++; $display("FAIL hold_handshake got=%0b/%0b exp=0/0", out_valid, in_ready); end
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("hold: cycle %0d occ=%0d out_data=%0h", c, occupancy, out_data);
      checks++; if (occupancy !== 2'd1 || out_data !== 96'h55 || out_valid !== 1'b0)
        begin failures++; $display("FAIL hold_state c=%0d got=%0d/%0h/%0b exp=1/55/0", c, occupancy, out_data, out_valid); end
    end
    hold = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== 96'h55 || out_ctrl !== 9'h0A3)
      begin failures++; $display("FAIL hold_release got=%0b/%0h/%0h exp=1/55/a3", out_valid, out_data, out_ctrl); end
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL hold_once got=%0d/%0b exp=0/0", occupancy, out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 96'h1; in_ctrl = 9'h1FF;
    tick();
    in_data = 96'h2;
    tick();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_fill got=%0d exp=2", occupancy); end
    flush = 1'b1; in_data = 96'h3;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    $display("flush: occ=%0d out_ctrl=%0h flush_cnt=%0d", occupancy, out_ctrl, flush_cnt);
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL flush_empty got=%0d/%0b exp=0/0", occupancy, out_valid); end
    checks++; if (out_ctrl !== '0 || out_data !== '0)
      begin failures++; $display("FAIL flush_payload got=%0h/%0h exp=0/0", out_ctrl, out_data); end
    checks++; if (flush_cnt !== 2'd1) begin failures++; $display("FAIL flush_cnt_one got=%0d exp=1", flush_cnt); end
    tick();
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_dropped got=%0d exp=0", occupancy); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (flush_cnt !== 2'd1) begin failures++; $display("FAIL flush_cnt_empty got=%0d exp=1", flush_cnt); end
    in_valid = 1'b1; in_data = 96'h9; in_ctrl = 9'h005;
    tick();
    in_valid = 1'b0; hold = 1'b1; flush = 1'b1;
    tick();
    hold = 1'b0; flush = 1'b0;
    $display("flush: during hold occ=%0d flush_cnt=%0d", occupancy, flush_cnt);
    checks++; if (occupancy !== 2'd0 || flush_cnt !== 2'd2)
      begin failures++; $display("FAIL flush_over_hold got=%0d/%0d exp=0/2", occupancy, flush_cnt); end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    exp_cnt = 2;
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0; in_valid = 1'b1; in_data = DATA_W'(i + 16); in_ctrl = 9'h010;
      tick();
      in_valid = 1'b0; flush = 1'b1;
      tick();
      flush = 1'b0;
      exp_cnt = (exp_cnt < 3) ? exp_cnt + 1 : 3;
      $display("saturation: flush %0d flush_cnt=%0d", i, flush_cnt);
      checks++; if (flush_cnt !== CNT_W'(exp_cnt))
        begin failures++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, flush_cnt, exp_cnt); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 96'h77; in_ctrl = 9'h0F0;
    tick();
    checks++; if (occupancy !== 2'd1 || out_data !== 96'h77)
      begin failures++; $display("FAIL areset_pre got=%0d/%0h exp=1/77", occupancy, out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: out_valid=%0b occ=%0d flush_cnt=%0d", out_valid, occupancy, flush_cnt);
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0)
      begin failures++; $display("FAIL areset_valid got=%0b/%0d exp=0/0", out_valid, occupancy); end
    checks++; if (out_data !== '0 || out_ctrl !== '0 || flush_cnt !== '0)
      begin failures++; $display("FAIL areset_zero got=%0h/%0h/%0d exp=0/0/0", out_data, out_ctrl, flush_cnt); end
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || occupancy !== 2'd0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL areset_release got=%0b/%0d/%0b exp=1/0/0", in_ready, occupancy, out_valid); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_hold();
    test_flush();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
